cp_window_metric: RTL and testbench



---
 rtl/cp_window_metric.sv | 258 +++++++++++++++++++++++++
 tb/tb_cp_window_metric.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cp_window_metric.sv
// cp_window_metric: windowed cyclic-prefix correlation/energy metric for OFDM
// timing sync. Runtime N (delay) and L (window); outputs gamma and phi per sample.
// Build macro METRIC_SAT_EN: when defined, outputs saturate and out_sat flags a
// clip; when undefined, outputs wrap to WL_OUT bits and out_sat stays 0.
module cp_window_metric #(
   parameter int WL_IN  = 16,
   parameter int WL_RHO = 8,
   parameter int WL_OUT = 20,
   parameter int MAX_N  = 1024,
   parameter int MAX_L  = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_load,
   input  logic [3:0]               cfg_n_log2,
   input  logic [$clog2(MAX_L):0]   cfg_l,
   input  logic signed [WL_RHO-1:0] cfg_rho,
   output logic                     cfg_err,
   input  logic                     in_valid,
   input  logic signed [WL_IN-1:0]  r_real_in,
   input  logic signed [WL_IN-1:0]  r_imag_in,
   output logic                     out_valid,
   output logic signed [WL_OUT-1:0] gamma_real_out,
   output logic signed [WL_OUT-1:0] gamma_imag_out,
   output logic signed [WL_OUT-1:0] phi_out,
   output logic                     out_sat
);
   localparam int NA  = $clog2(MAX_N);
   localparam int LA  = $clog2(MAX_L);
   localparam int CW  = (NA > LA) ? NA : LA;
   localparam int PW  = 2*WL_IN + 1;          // correlation term width
   localparam int TW  = 2*WL_IN + 2;          // energy term width
   localparam int GW  = 2*WL_IN + 1 + LA;     // gamma accumulator
   localparam int EW  = 2*WL_IN + 2 + LA;     // energy accumulator
   localparam int XW  = EW + WL_RHO;          // energy * rho
   localparam int WW  = 2*PW + TW;            // window line word
   localparam int GSH = 2*(WL_IN-1) - (WL_OUT-3);
   // the extra 1 folds the rho/2 halving into the final shift (floor is preserved)
   localparam int PSH = 2*(WL_IN-1) + WL_RHO - 1 - (WL_OUT-3) + 1;
`ifdef METRIC_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, FILL, WARM, RUN} state_t;
   // sample tags: add to window only / add and emit (last warm-up) / full update
   localparam logic [1:0] K_NONE = 2'd0, K_ADD = 2'd1, K_LAST = 2'd2, K_RUN = 2'd3;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [NA-1:0]    n_m1_reg;
   logic [LA-1:0]    l_m1_reg;
   logic signed [WL_RHO-1:0] rho_reg;

   logic [31:0]      n_ext, l_ext;
   logic             cfg_legal, flush, accept;
   logic [1:0]       kind_in;

   assign n_ext     = 32'd1 << cfg_n_log2;
   assign l_ext     = 32'(cfg_l);
   assign cfg_legal = (cfg_n_log2 >= 4'd4) && (32'(cfg_n_log2) <= 32'(NA)) &&
                      (l_ext != 32'd0) && (l_ext <= 32'(MAX_L)) && (l_ext <= n_ext);
   assign flush     = cfg_load && cfg_legal;
   assign accept    = in_valid && !flush && (state_reg != IDLE);

   // phase state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // phase sequencing: FILL counts N samples, WARM counts L samples
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      kind_in    = K_NONE;
      if (flush) begin
         state_next = FILL;
         cnt_next   = '0;
      end else if (in_valid) begin
         case (state_reg)
            FILL: begin
               if (cnt_reg == CW'(n_m1_reg)) begin
                  state_next = WARM;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            WARM: begin
               if (cnt_reg == CW'(l_m1_reg)) begin
                  state_next = RUN;
                  cnt_next   = '0;
                  kind_in    = K_LAST;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
                  kind_in  = K_ADD;
               end
            end
            RUN:     kind_in = K_RUN;
            default: ;
         endcase
      end
   end

   // configuration latch and illegal-config pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         n_m1_reg <= '0;
         l_m1_reg <= '0;
         rho_reg  <= '0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_err <= cfg_load && !cfg_legal;
         if (flush) begin
            n_m1_reg <= NA'(n_ext - 32'd1);
            l_m1_reg <= LA'(l_ext - 32'd1);
            rho_reg  <= cfg_rho;
         end
      end
   end

   // sample delay RAM: read-before-write yields r(n-N) from the slot r(n) replaces
   logic [2*WL_IN-1:0] smp_mem [MAX_N];
   logic [2*WL_IN-1:0] smp_rd_reg;
   logic [NA-1:0]      wr_ptr_reg;
   always_ff @(posedge clk) begin
      if (accept)
         smp_mem[wr_ptr_reg] <= {r_real_in, r_imag_in};
      smp_rd_reg <= smp_mem[wr_ptr_reg];
   end

   logic signed [WL_IN-1:0] a1_reg, b1_reg, c1, d1;
   logic signed [PW-1:0]    cre2_reg, cim2_reg, cre3_reg, cim3_reg;
   logic signed [TW-1:0]    e2_reg, e3_reg;
   logic [1:0]              k1_reg, k2_reg, k3_reg;
   assign c1 = smp_rd_reg[2*WL_IN-1:WL_IN];
   assign d1 = smp_rd_reg[WL_IN-1:0];

   // datapath registers; validity is carried by the k*_reg tags
   always_ff @(posedge clk) begin
      a1_reg   <= r_real_in;
      b1_reg   <= r_imag_in;
      cre2_reg <= PW'(a1_reg) * PW'(c1) + PW'(b1_reg) * PW'(d1);
      cim2_reg <= PW'(b1_reg) * PW'(c1) - PW'(a1_reg) * PW'(d1);
      e2_reg   <= TW'(a1_reg) * TW'(a1_reg) + TW'(b1_reg) * TW'(b1_reg) +
                  TW'(c1) * TW'(c1) + TW'(d1) * TW'(d1);
      cre3_reg <= cre2_reg;
      cim3_reg <= cim2_reg;
      e3_reg   <= e2_reg;
   end

   // window delay line RAM: returns the term written L samples earlier
   logic [WW-1:0] win_mem [MAX_L];
   logic [WW-1:0] win_rd_reg;
   logic [LA-1:0] win_ptr_reg;
   always_ff @(posedge clk) begin
      if (k2_reg != K_NONE)
         win_mem[win_ptr_reg] <= {cre2_reg, cim2_reg, e2_reg};
      win_rd_reg <= win_mem[win_ptr_reg];
   end

   logic signed [PW-1:0] old_re, old_im;
   logic signed [TW-1:0] old_e;
   assign old_re = win_rd_reg[WW-1 -: PW];
   assign old_im = win_rd_reg[WW-PW-1 -: PW];
   assign old_e  = win_rd_reg[TW-1:0];

   logic signed [GW-1:0] gre_reg, gim_reg, gre_next, gim_next, gre_sub, gim_sub;
   logic signed [EW-1:0] e_reg, e_next, e_sub;

   // running window sums: add the new term, drop the one leaving the window
   always_comb begin
      gre_sub  = '0;
      gim_sub  = '0;
      e_sub    = '0;
      gre_next = gre_reg;
      gim_next = gim_reg;
      e_next   = e_reg;
      if (k3_reg == K_RUN) begin
         gre_sub = GW'(old_re);
         gim_sub = GW'(old_im);
         e_sub   = EW'(old_e);
      end
      if (k3_reg != K_NONE) begin
         gre_next = gre_reg + GW'(cre3_reg) - gre_sub;
         gim_next = gim_reg + GW'(cim3_reg) - gim_sub;
         e_next   = e_reg + EW'(e3_reg) - e_sub;
      end
   end

   // tags, pointers and accumulators; cleared on reset and on a legal reload
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         k1_reg      <= K_NONE;
         k2_reg      <= K_NONE;
         k3_reg      <= K_NONE;
         wr_ptr_reg  <= '0;
         win_ptr_reg <= '0;
         gre_reg     <= '0;
         gim_reg     <= '0;
         e_reg       <= '0;
      end else begin
         k1_reg   <= kind_in;
         k2_reg   <= k1_reg;
         k3_reg   <= k2_reg;
         gre_reg  <= gre_next;
         gim_reg  <= gim_next;
         e_reg    <= e_next;
         if (accept)
            wr_ptr_reg <= (wr_ptr_reg == n_m1_reg) ? '0 : wr_ptr_reg + 1'b1;
         if (k2_reg != K_NONE)
            win_ptr_reg <= (win_ptr_reg == l_m1_reg) ? '0 : win_ptr_reg + 1'b1;
      end
   end

   // scaled results, all sign-extended to a common width before range check
   logic signed [XW-1:0]     sh [3];
   logic signed [WL_OUT-1:0] res [3];
   logic [2:0]               clip;
   assign sh[0] = XW'(gre_next >>> GSH);
   assign sh[1] = XW'(gim_next >>> GSH);
   assign sh[2] = (XW'(e_next) * XW'(rho_reg)) >>> PSH;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_sat
         logic hi_same;
         assign hi_same  = (sh[gi][XW-1:WL_OUT-1] == {(XW-WL_OUT+1){sh[gi][XW-1]}});
         assign clip[gi] = SAT_EN & ~hi_same;
         assign res[gi]  = !clip[gi] ? sh[gi][WL_OUT-1:0] :
                           (sh[gi][XW-1] ? {1'b1, {(WL_OUT-1){1'b0}}}
                                         : {1'b0, {(WL_OUT-1){1'b1}}});
      end
   endgenerate

   // output registers: hold zero whenever no result is emitted
   always_ff @(posedge clk) begin
      if (rst || flush || !(k3_reg == K_LAST || k3_reg == K_RUN)) begin
         out_valid      <= 1'b0;
         gamma_real_out <= '0;
         gamma_imag_out <= '0;
         phi_out        <= '0;
         out_sat        <= 1'b0;
      end else begin
         out_valid      <= 1'b1;
         gamma_real_out <= res[0];
         gamma_imag_out <= res[1];
         phi_out        <= res[2];
         out_sat        <= |clip;
      end
   end
endmodule

// File: tb/tb_cp_window_metric.sv
// tb_cp_window_metric: directed + random stimulus with a scoreboard of expected
// metric outputs computed by direct windowed summation over the sample history.
`timescale 1ns/1ps
module tb_cp_window_metric;
   localparam int WL_IN = 16, WL_RHO = 8, WL_OUT = 20, MAX_N = 1024, MAX_L = 256;
   localparam int GSH = 2*(WL_IN-1) - (WL_OUT-3);
   localparam int PSH = 2*(WL_IN-1) + WL_RHO - 1 - (WL_OUT-3);

   logic clk = 1'b0;
   logic rst, cfg_load, cfg_err, in_valid, out_valid, out_sat;
   logic [3:0] cfg_n_log2;
   logic [8:0] cfg_l;
   logic signed [7:0] cfg_rho;
   logic signed [15:0] r_real_in, r_imag_in;
   logic signed [19:0] gamma_real_out, gamma_imag_out, phi_out;

   cp_window_metric #(.WL_IN(WL_IN), .WL_RHO(WL_RHO), .WL_OUT(WL_OUT),
                      .MAX_N(MAX_N), .MAX_L(MAX_L)) dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_n_log2(cfg_n_log2),
      .cfg_l(cfg_l), .cfg_rho(cfg_rho), .cfg_err(cfg_err), .in_valid(in_valid),
      .r_real_in(r_real_in), .r_imag_in(r_imag_in), .out_valid(out_valid),
      .gamma_real_out(gamma_real_out), .gamma_imag_out(gamma_imag_out),
      .phi_out(phi_out), .out_sat(out_sat));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic signed [19:0] g_re, g_im, phi;
      logic sat;
      int due;
   } exp_t;

   exp_t sbq[$];
   int   h_re[$], h_im[$];
   int   err_due = -1;
   bit   m_active = 0;
   int   m_n, m_l;
   longint m_rho;
   int   errors = 0, checks = 0;
   bit   mon_en = 0;

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   function automatic void scale(input longint x, output logic signed [19:0] y,
                                 output logic s);
`ifdef METRIC_SAT_EN
      if (x > 524287) begin
         y = 20'h7FFFF; s = 1'b1;
      end else if (x < -524288) begin
         y = 20'h80000; s = 1'b1;
      end else begin
         y = 20'(x); s = 1'b0;
      end
`else
      y = 20'(x);
      s = 1'b0;
`endif
   endfunction

   // expected output for history index k, by direct summation over the window
   function automatic exp_t model_out(input int k);
      exp_t e;
      longint gre = 0, gim = 0, en = 0;
      logic s0, s1, s2;
      for (int j = k - m_l + 1; j <= k; j++) begin
         longint a, b, c, d;
         a = h_re[j]; b = h_im[j]; c = h_re[j-m_n]; d = h_im[j-m_n];
         gre += a*c + b*d;
         gim += b*c - a*d;
         en  += a*a + b*b + c*c + d*d;
      end
      scale(gre >>> GSH, e.g_re, s0);
      scale(gim >>> GSH, e.g_im, s1);
      scale(((en * m_rho) >>> 1) >>> PSH, e.phi, s2);
      e.sat = s0 | s1 | s2;
      e.due = cyc + 4;
      return e;
   endfunction

   function automatic void drop_after(input int c);
      while (sbq.size() != 0 && sbq[$].due > c) void'(sbq.pop_back());
   endfunction

   // drive one cycle of inputs and advance the reference model
   task automatic step(input bit v, input int re, input int im, input bit ld,
                       input int nl, input int l, input int rho, input bit rs);
      bit legal;
      @(posedge clk); #1;
      rst = rs; in_valid = v; r_real_in = 16'(re); r_imag_in = 16'(im);
      cfg_load = ld; cfg_n_log2 = 4'(nl); cfg_l = 9'(l); cfg_rho = 8'(rho);
      legal = (nl >= 4) && (nl <= 10) && (l >= 1) && (l <= MAX_L) && (l <= (1 << nl));
      if (rs) begin
         m_active = 0;
         drop_after(cyc);
      end else if (ld && legal) begin
         m_active = 1; m_n = 1 << nl; m_l = l; m_rho = rho;
         h_re.delete(); h_im.delete();
         drop_after(cyc);
      end else begin
         if (ld) err_due = cyc + 1;
         if (v && m_active) begin
            h_re.push_back(re); h_im.push_back(im);
            if (h_re.size() - 1 >= m_n + m_l - 1) sbq.push_back(model_out(h_re.size() - 1));
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic int rnd16();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   // output monitor: compare against the scoreboard, else require idle zeros
   always @(negedge clk) begin
      if (mon_en) begin
         if (sbq.size() != 0 && sbq[0].due == cyc) begin
            exp_t e;
            e = sbq.pop_front();
            check("out_valid", 64'(out_valid), 64'(1'b1));
            check("gamma_real", 64'(gamma_real_out), 64'(e.g_re));
            check("gamma_imag", 64'(gamma_imag_out), 64'(e.g_im));
            check("phi", 64'(phi_out), 64'(e.phi));
            check("out_sat", 64'(out_sat), 64'(e.sat));
            $display("out cyc=%0d g_re=%0d g_im=%0d phi=%0d sat=%0d",
                     cyc, gamma_real_out, gamma_imag_out, phi_out, out_sat);
         end else begin
            check("idle_outputs",
                  {2'b00, out_valid, out_sat, gamma_real_out, gamma_imag_out, phi_out},
                  64'd0);
         end
         check("cfg_err", 64'(cfg_err), 64'(err_due == cyc));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1; cfg_load = 0; in_valid = 0; r_real_in = 0; r_imag_in = 0;
      cfg_n_log2 = 0; cfg_l = 0; cfg_rho = 0;
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      mon_en = 1;
      step(0, 0, 0, 0, 0, 0, 0, 1);
      idle(3);
      // samples in IDLE are ignored
      for (int i = 0; i < 5; i++) step(1, 500, 3, 0, 0, 0, 0, 0);
      // illegal configurations from IDLE
      step(1, 7, 7, 1, 4, 0, 64, 0);  idle(2);
      step(0, 0, 0, 1, 4, 17, 64, 0); idle(2);
      step(1, 9, 9, 1, 3, 4, 64, 0);  idle(2);
      step(0, 0, 0, 1, 11, 4, 64, 0); idle(2);
      for (int i = 0; i < 3; i++) step(1, 1000, 0, 0, 0, 0, 0, 0);
      // N=16 L=4 rho=64, constant (1000,0); strobe-cycle sample discarded
      step(1, 1000, 0, 1, 4, 4, 64, 0);
      for (int i = 0; i < 30; i++) step(1, 1000, 0, 0, 0, 0, 0, 0);
      // illegal reload during RUN: pulse only, processing continues
      step(1, 1000, 0, 1, 4, 0, 64, 0);
      for (int i = 0; i < 5; i++) step(1, 1000, 0, 0, 0, 0, 0, 0);
      step(1, 1000, 0, 1, 5, 33, 64, 0);
      for (int i = 0; i < 3; i++) step(1, 1000, 0, 0, 0, 0, 0, 0);
      // same stimulus with in_valid toggling every other cycle
      step(0, 0, 0, 1, 4, 4, 64, 0);
      for (int i = 0; i < 60; i++) step(i[0] == 1'b0, 1000, 0, 0, 0, 0, 0, 0);
      // random data with random gaps, rho=100
      step(0, 0, 0, 1, 4, 4, 100, 0);
      for (int i = 0; i < 60; i++) step($urandom_range(0, 3) != 0, rnd16(), rnd16(), 0, 0, 0, 0, 0);
      // full-scale input, L=N=16, rho=127
      step(0, 0, 0, 1, 4, 16, 127, 0);
      for (int i = 0; i < 40; i++) step(1, 32767, 32767, 0, 0, 0, 0, 0);
      // mid-RUN reload to N=32 L=8 with a sample in the strobe cycle
      step(1, 32767, 32767, 1, 5, 8, 64, 0);
      for (int i = 0; i < 45; i++) step(1, rnd16(), rnd16(), 0, 0, 0, 0, 0);
      // deepest window: N=256 L=256, random data
      step(0, 0, 0, 1, 8, 256, 64, 0);
      for (int i = 0; i < 530; i++) step(1, rnd16(), rnd16(), 0, 0, 0, 0, 0);
      // L=1 edge case
      step(0, 0, 0, 1, 4, 1, 90, 0);
      for (int i = 0; i < 25; i++) step(1, rnd16(), rnd16(), 0, 0, 0, 0, 0);
      // reset mid-RUN: outputs clear next cycle, samples then ignored
      step(1, 1234, -567, 0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(1, 1234, -567, 0, 0, 0, 0, 0);
      idle(8);
      check("drain", 64'(sbq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
